stream_demux_1to2: RTL and testbench

- 1-to-2 stream demultiplexer; inverse of the datapath 2-to-1 selector.
- Routes each accepted input word to output 0 or 1 according to select_i, sampled with the word.
- Each output has its own 2-entry FIFO, so a stalled consumer blocks only words steered toward it.
- Sits between a producer stage and two downstream consumers, e.g. a write-back/forwarding split in the pipelined CPU.

---
 rtl/stream_demux_1to2.sv | 123 ++++++++++++
 tb/tb_stream_demux_1to2.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1to2.sv
// Steers each accepted input word to output 0 or 1 by select_i; each output owns a 2-entry FIFO.
// Latency: one cycle into an empty FIFO; otherwise the word waits behind older words of that FIFO.
// Backpressure: ready_o drops only while the selected FIFO is full; a pop frees space one cycle later.
// Optional: define STREAM_DEMUX_CNT_EN to add saturating 16-bit push counters cnt0_o / cnt1_o.

module stream_demux_fifo2 #(
    parameter int width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_vld,
    input  logic [width-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [width-1:0] head_dat,
    output logic [1:0]       occ
);
    logic [width-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_pop;

    // Popping an empty FIFO is ignored, so an idle consumer's ready has no effect.
    assign do_pop   = pop_rdy & (occ != 2'd0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_vld, do_pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

module stream_demux_1to2 #(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [size-1:0] data_i,
    input  logic            select_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [size-1:0] data0_o,
    output logic            valid0_o,
    input  logic            ready0_i,
    output logic [size-1:0] data1_o,
    output logic            valid1_o,
    input  logic            ready1_i
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [15:0]     cnt0_o,
    output logic [15:0]     cnt1_o
`endif
);
    logic [1:0] occ0;
    logic [1:0] occ1;
    logic       push0;
    logic       push1;
    logic       pop0;
    logic       pop1;

    // Full is judged on registered occupancy only, so a same-cycle pop never opens the input.
    assign ready_o  = (select_i ? occ1 : occ0) != 2'd2;
    assign push0    = valid_i & ready_o & ~select_i;
    assign push1    = valid_i & ready_o & select_i;
    assign valid0_o = (occ0 != 2'd0);
    assign valid1_o = (occ1 != 2'd0);
    assign pop0     = valid0_o & ready0_i;
    assign pop1     = valid1_o & ready1_i;

    stream_demux_fifo2 #(.width(size)) u_fifo0 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_vld (push0),
        .push_dat (data_i),
        .pop_rdy  (pop0),
        .head_dat (data0_o),
        .occ      (occ0)
    );

    stream_demux_fifo2 #(.width(size)) u_fifo1 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_vld (push1),
        .push_dat (data_i),
        .pop_rdy  (pop1),
        .head_dat (data1_o),
        .occ      (occ1)
    );

`ifdef STREAM_DEMUX_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt0_o <= 16'd0;
            cnt1_o <= 16'd0;
        end else begin
            if (push0 && cnt0_o != 16'hFFFF) begin
                cnt0_o <= cnt0_o + 16'd1;
            end
            if (push1 && cnt1_o != 16'hFFFF) begin
                cnt1_o <= cnt1_o + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed bench for stream_demux_1to2: expected words queued at acceptance, checked by a monitor on pop.
module tb_stream_demux_1to2;
    logic        clk_i;
    logic        rst_i;
    logic [31:0] data_i;
    logic        select_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data0_o;
    logic        valid0_o;
    logic        ready0_i;
    logic [31:0] data1_o;
    logic        valid1_o;
    logic        ready1_i;
`ifdef STREAM_DEMUX_CNT_EN
    logic [15:0] cnt0_o;
    logic [15:0] cnt1_o;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    stream_demux_1to2 #(.size(32)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .select_i (select_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data0_o  (data0_o),
        .valid0_o (valid0_o),
        .ready0_i (ready0_i),
        .data1_o  (data1_o),
        .valid1_o (valid1_o),
        .ready1_i (ready1_i)
`ifdef STREAM_DEMUX_CNT_EN
        ,
        .cnt0_o   (cnt0_o),
        .cnt1_o   (cnt1_o)
`endif
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: any handshake on an output must deliver the oldest expected word of that output.
    always @(negedge clk_i) begin
        if (rst_i && valid0_o && ready0_i) begin
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out0_unexpected: got %h, expected no word", data0_o);
            end else begin
                check("out0_data", data0_o, q0.pop_front());
            end
        end
        if (rst_i && valid1_o && ready1_i) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out1_unexpected: got %h, expected no word", data1_o);
            end else begin
                check("out1_data", data1_o, q1.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_word(input logic [31:0] d, input logic s, input logic exp_rdy);
        data_i   = d;
        select_i = s;
        valid_i  = 1'b1;
        @(negedge clk_i);
        check("ready_o", {31'd0, ready_o}, {31'd0, exp_rdy});
        if (ready_o) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
        end
        cyc();
        valid_i = 1'b0;
    endtask

    task automatic drain();
        ready0_i = 1'b1;
        ready1_i = 1'b1;
        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) begin
            cyc();
        end
        cyc();
        check("drain_q0_empty", q0.size(), 32'd0);
        check("drain_q1_empty", q1.size(), 32'd0);
        @(negedge clk_i);
        check("drain_valid0", {31'd0, valid0_o}, 32'd0);
        check("drain_valid1", {31'd0, valid1_o}, 32'd0);
        cyc();
    endtask

    initial begin
        rst_i    = 1'b0;
        data_i   = 32'd0;
        select_i = 1'b0;
        valid_i  = 1'b0;
        ready0_i = 1'b0;
        ready1_i = 1'b0;
        #3;
        check("rst_valid0", {31'd0, valid0_o}, 32'd0);
        check("rst_valid1", {31'd0, valid1_o}, 32'd0);
        check("rst_data0", data0_o, 32'd0);
        check("rst_data1", data1_o, 32'd0);
        check("rst_ready_sel0", {31'd0, ready_o}, 32'd1);
        select_i = 1'b1;
        #1;
        check("rst_ready_sel1", {31'd0, ready_o}, 32'd1);
        select_i = 1'b0;
`ifdef STREAM_DEMUX_CNT_EN
        check("rst_cnt0", {16'd0, cnt0_o}, 32'd0);
        check("rst_cnt1", {16'd0, cnt1_o}, 32'd0);
`endif
        cyc();
        rst_i = 1'b1;
        cyc();

        // Steering: each word on its own output for exactly one cycle.
        ready0_i = 1'b1;
        ready1_i = 1'b1;
        drive_word(32'hA5A5_0001, 1'b0, 1'b1);
        @(negedge clk_i);
        check("steer_v0_on", {31'd0, valid0_o}, 32'd1);
        check("steer_v1_off", {31'd0, valid1_o}, 32'd0);
        cyc();
        @(negedge clk_i);
        check("steer_v0_one_cycle", {31'd0, valid0_o}, 32'd0);
        cyc();
        drive_word(32'h5A5A_0002, 1'b1, 1'b1);
        @(negedge clk_i);
        check("steer_v1_on", {31'd0, valid1_o}, 32'd1);
        check("steer_v0_stays_off", {31'd0, valid0_o}, 32'd0);
        cyc();
        @(negedge clk_i);
        check("steer_v1_one_cycle", {31'd0, valid1_o}, 32'd0);
        cyc();

        // Full/backpressure: third word refused even while the head pops.
        ready0_i = 1'b0;
        drive_word(32'd1, 1'b0, 1'b1);
        drive_word(32'd2, 1'b0, 1'b1);
        ready0_i = 1'b1;
        drive_word(32'd3, 1'b0, 1'b0);
        drive_word(32'd3, 1'b0, 1'b1);
        drain();

        // Isolation: a full FIFO 0 does not block output 1.
        ready0_i = 1'b0;
        ready1_i = 1'b0;
        drive_word(32'd20, 1'b0, 1'b1);
        drive_word(32'd21, 1'b0, 1'b1);
        drive_word(32'd7, 1'b1, 1'b1);
        @(negedge clk_i);
        check("iso_valid1", {31'd0, valid1_o}, 32'd1);
        check("iso_data1", data1_o, 32'd7);
        check("iso_data0_held", data0_o, 32'd20);
        select_i = 1'b0;
        #1;
        check("iso_ready_sel0_full", {31'd0, ready_o}, 32'd0);
        cyc();
        drain();

        // Simultaneous push and pop on a one-entry FIFO.
        ready0_i = 1'b0;
        drive_word(32'd10, 1'b0, 1'b1);
        ready0_i = 1'b1;
        drive_word(32'd11, 1'b0, 1'b1);
        ready0_i = 1'b0;
        @(negedge clk_i);
        check("pp_valid0", {31'd0, valid0_o}, 32'd1);
        check("pp_data0", data0_o, 32'd11);
        select_i = 1'b0;
        #1;
        check("pp_ready_occ1", {31'd0, ready_o}, 32'd1);
        cyc();
        drain();

        // Reset mid-operation discards buffered words at once.
        ready0_i = 1'b0;
        ready1_i = 1'b0;
        drive_word(32'hDEAD_0001, 1'b0, 1'b1);
        drive_word(32'hDEAD_0002, 1'b0, 1'b1);
        drive_word(32'hBEEF_0003, 1'b1, 1'b1);
        #2;
        rst_i = 1'b0;
        #1;
        check("mid_rst_valid0", {31'd0, valid0_o}, 32'd0);
        check("mid_rst_valid1", {31'd0, valid1_o}, 32'd0);
        check("mid_rst_data0", data0_o, 32'd0);
        check("mid_rst_data1", data1_o, 32'd0);
        check("mid_rst_ready", {31'd0, ready_o}, 32'd1);
`ifdef STREAM_DEMUX_CNT_EN
        check("mid_rst_cnt0", {16'd0, cnt0_o}, 32'd0);
        check("mid_rst_cnt1", {16'd0, cnt1_o}, 32'd0);
`endif
        q0.delete();
        q1.delete();
        cyc();
        rst_i = 1'b1;
        cyc();
        drain();

`ifdef STREAM_DEMUX_CNT_EN
        // Counter saturation with back-to-back sel-0 traffic.
        ready0_i = 1'b1;
        select_i = 1'b0;
        valid_i  = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            data_i = i;
            @(negedge clk_i);
            if (ready_o) q0.push_back(data_i);
            cyc();
        end
        valid_i = 1'b0;
        @(negedge clk_i);
        check("cnt0_saturated", {16'd0, cnt0_o}, 32'h0000_FFFF);
        check("cnt1_zero", {16'd0, cnt1_o}, 32'd0);
        cyc();
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
